// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_unit_pkg;

   // Default bus widths for the RV32I core
   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_DATA_WIDTH = 32;

   // Size of one instruction word in bytes; sequential fetch advances by this
   localparam int INSTR_BYTES = 4;

   typedef logic [DEF_ADDR_WIDTH-1:0] ADDR_BUS;
   typedef logic [DEF_DATA_WIDTH-1:0] DATA_BUS;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      VALID = 2'd2,
      ERROR = 2'd3
   } fetch_state;

   // True when an address sits on an instruction-word boundary
   function automatic logic is_word_aligned(input logic [1:0] low_bits);
      return (low_bits == 2'b00);
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory and instruction-stream handshakes of the fetch stage
interface fetch_unit_if
   import fetch_unit_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

   // Instruction-memory read channel
   logic                  imem_req;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic                  imem_ack;
   logic [DATA_WIDTH-1:0] imem_rdata;

   // Fetched-instruction channel towards the control unit
   logic [DATA_WIDTH-1:0] instr;
   logic                  instr_valid;
   logic                  instr_ready;
   logic [ADDR_WIDTH-1:0] PC_out;

   // Fetch-stage side
   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata,
      output instr,
      output instr_valid,
      input  instr_ready,
      output PC_out
   );

   // Memory and consumer side
   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata,
      input  instr,
      input  instr_valid,
      output instr_ready,
      input  PC_out
   );

endinterface

// File: rtl/fetch_unit_pc_next_calc.sv
// rtl/fetch_unit_pc_next_calc.sv - next-PC adder with word-alignment check
module pc_next_calc
   import fetch_unit_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic [ADDR_WIDTH-1:0] pc_i,
   input  logic                  pcsrc_i,
   input  logic [ADDR_WIDTH-1:0] imm_i,
   output logic [ADDR_WIDTH-1:0] next_pc_o,
   output logic                  misaligned_o
);

   logic [ADDR_WIDTH-1:0] offset;

   // Branch offset or sequential step, added modulo 2^ADDR_WIDTH (wrap is legal)
   always_comb begin
      offset       = pcsrc_i ? imm_i : ADDR_WIDTH'(INSTR_BYTES);
      next_pc_o    = pc_i + offset;
      misaligned_o = !is_word_aligned(next_pc_o[1:0]);
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I instruction-fetch stage: PC, imem req/ack, instr valid/ready
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  PCsrc,
   input  logic [ADDR_WIDTH-1:0] ImmOp,
   output logic                  fetch_err,
   fetch_unit_if.master          bus
);

   fetch_state            state_q;
   logic [ADDR_WIDTH-1:0] pc_q;
   logic [ADDR_WIDTH-1:0] pc_out_q;
   logic [DATA_WIDTH-1:0] instr_q;

   logic [ADDR_WIDTH-1:0] pc_d;
   logic                  pc_d_misaligned;

   // Branch/sequential target; only consumed in the cycle the instruction is accepted
   pc_next_calc #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_pc_next_calc (
      .pc_i         (pc_q),
      .pcsrc_i      (PCsrc),
      .imm_i        (ImmOp),
      .next_pc_o    (pc_d),
      .misaligned_o (pc_d_misaligned)
   );

   // Fetch FSM with PC and presented-instruction registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         pc_out_q <= '0;
         instr_q  <= '0;
      end else begin
         case (state_q)
            // One dead cycle after reset swallows any ack left over from a cut-off request
            IDLE: begin
               state_q <= FETCH;
            end
            FETCH: begin
               if (bus.imem_ack) begin
                  instr_q  <= bus.imem_rdata;
                  pc_out_q <= pc_q;
                  state_q  <= VALID;
               end
            end
            // Hold the instruction until the consumer takes it, then redirect or step
            VALID: begin
               if (bus.instr_ready) begin
                  if (pc_d_misaligned) begin
                     state_q <= ERROR;
                  end else begin
                     pc_q    <= pc_d;
                     state_q <= FETCH;
                  end
               end
            end
            // Sticky until reset; PC keeps the address of the offending instruction
            ERROR: begin
               state_q <= ERROR;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.imem_req    = (state_q == FETCH);
   assign bus.imem_addr   = pc_q;
   assign bus.instr       = instr_q;
   assign bus.instr_valid = (state_q == VALID);
   assign bus.PC_out      = pc_out_q;
   assign fetch_err       = (state_q == ERROR);

endmodule
